// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared BCD/display types, state encodings and digit helpers
package display_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_t;

   // Walks from the most significant digit down: a digit is blank only while
   // it and everything above it are zero.
   function automatic logic blank_next(input logic [BCD_DIGIT_W-1:0] digit,
                                       input logic upper_blank);
      return upper_blank && (digit == '0);
   endfunction

   function automatic logic [6:0] seg_code(input logic [BCD_DIGIT_W-1:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
   import display_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adjusted
);

   assign adjusted = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/out_bcd_converter.sv
// rtl/out_bcd_converter.sv - sequential binary-to-BCD converter feeding the 7-segment display stage
module out_bcd_converter
   import display_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIGITS = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [DATA_W-1:0]           DIN,
   input  logic                        LOAD,
   output logic                        BUSY,
   output logic                        DONE,
   output logic                        VALID,
   output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_OUT,
   output logic [DIGITS-1:0]           BLANK
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
   localparam longint MAX_IN = (longint'(1) << DATA_W) - 1;

   generate
      if (pow10(DIGITS) <= MAX_IN) begin : g_digits_too_few
         $error("DIGITS too small for DATA_W");
      end
   endgenerate

   conv_state_t state, next_state;

   logic [DATA_W-1:0] bin_sr;
   logic [DATA_W-1:0] pend_d;
   logic              pend_v;
   logic [BCD_W-1:0]  bcd_sr;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt;
   logic [DIGITS-1:0] mask;
   logic              upper_blank;
   logic              start;
   logic              start_from_pend;
   logic              shift_en;
   logic              commit;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit    (bcd_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   always_comb begin
      mask        = '0;
      upper_blank = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_blank = blank_next(bcd_sr[i*BCD_DIGIT_W +: BCD_DIGIT_W], upper_blank);
         mask[i]     = upper_blank;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= next_state;
   end

   // A LOAD seen in COMMIT is the newest value, so it beats anything pending.
   always_comb begin
      next_state      = state;
      start           = 1'b0;
      start_from_pend = 1'b0;
      shift_en        = 1'b0;
      commit          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (LOAD) begin
               start      = 1'b1;
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CNT_LAST) next_state = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit = 1'b1;
            if (LOAD) begin
               start      = 1'b1;
               next_state = ST_SHIFT;
            end else if (pend_v) begin
               start           = 1'b1;
               start_from_pend = 1'b1;
               next_state      = ST_SHIFT;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bin_sr  <= '0;
         bcd_sr  <= '0;
         cnt     <= '0;
         pend_d  <= '0;
         pend_v  <= 1'b0;
         BCD_OUT <= '0;
         BLANK   <= BLANK_RST;
         VALID   <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         DONE <= commit;
         if (start) begin
            bin_sr <= start_from_pend ? pend_d : DIN;
            bcd_sr <= '0;
            cnt    <= '0;
         end else if (shift_en) begin
            bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
            bin_sr <= bin_sr << 1;
            cnt    <= cnt + CNT_W'(1);
         end
         if (commit) begin
            BCD_OUT <= bcd_sr;
            BLANK   <= mask;
            VALID   <= 1'b1;
         end
         if (LOAD && state == ST_SHIFT) begin
            pend_d <= DIN;
            pend_v <= 1'b1;
         end else if (commit) begin
            pend_v <= 1'b0;
         end
      end
   end

   assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_out_bcd_converter.sv
// tb/tb_out_bcd_converter.sv - scoreboard bench for out_bcd_converter
module tb_out_bcd_converter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  DIN;
   logic        LOAD;
   logic        BUSY;
   logic        DONE;
   logic        VALID;
   logic [15:0] BCD_OUT;
   logic [3:0]  BLANK;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] exp_q[$];
   logic [3:0]  expb_q[$];
   logic [15:0] last_bcd;
   logic [3:0]  last_blank;

   out_bcd_converter #(.DATA_W(8), .DIGITS(4)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .DIN     (DIN),
      .LOAD    (LOAD),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .VALID   (VALID),
      .BCD_OUT (BCD_OUT),
      .BLANK   (BLANK)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   function automatic logic [3:0] ref_blank(input logic [15:0] b);
      logic [3:0] m;
      m[3] = (b[15:12] == 4'd0);
      m[2] = m[3] && (b[11:8] == 4'd0);
      m[1] = m[2] && (b[7:4] == 4'd0);
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic load_word(input logic [7:0] v);
      @(negedge CLK);
      DIN  = v;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         cycles++;
         if (DONE === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      LOAD  = 1'b0;
      DIN   = '0;
      repeat (2) @(negedge CLK);
      n_vec++; if (BCD_OUT !== 16'h0000) begin n_err++; $display("FAIL reset_bcd got %h want 0000", BCD_OUT); end
      n_vec++; if (BLANK !== 4'b1110) begin n_err++; $display("FAIL reset_blank got %b want 1110", BLANK); end
      n_vec++; if ({BUSY, DONE, VALID} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {BUSY, DONE, VALID}); end
      RESET = 1'b0;
      last_bcd   = 16'h0000;
      last_blank = 4'b1110;
   endtask

   task automatic test_known;
      logic [7:0]  vals [4];
      logic [15:0] exps [4];
      logic [3:0]  blks [4];
      int cyc; bit ok;
      vals = '{8'd0, 8'd255, 8'd7, 8'd100};
      exps = '{16'h0000, 16'h0255, 16'h0007, 16'h0100};
      blks = '{4'b1110, 4'b1000, 4'b1110, 4'b1000};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         expb_q.push_back(blks[i]);
         load_word(vals[i]);
         wait_done(cyc, ok);
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL known_timeout din %0d no DONE", vals[i]); exp_q.delete(); expb_q.delete(); continue; end
         n_vec++; if (cyc != 9) begin n_err++; $display("FAIL known_latency din %0d got %0d want 9", vals[i], cyc); end
         last_bcd = exp_q.pop_front();
         last_blank = expb_q.pop_front();
         n_vec++; if (BCD_OUT !== last_bcd) begin n_err++; $display("FAIL known_bcd din %0d got %h want %h", vals[i], BCD_OUT, last_bcd); end
         n_vec++; if (BLANK !== last_blank) begin n_err++; $display("FAIL known_blank din %0d got %b want %b", vals[i], BLANK, last_blank); end
         n_vec++; if (VALID !== 1'b1) begin n_err++; $display("FAIL known_valid din %0d got %b want 1", vals[i], VALID); end
      end
   endtask

   task automatic test_sweep;
      int cyc; bit ok;
      for (int v = 0; v < 256; v++) begin
         @(negedge CLK);
         n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL sweep_busy din %0d got %b want 0", v, BUSY); end
         exp_q.push_back(ref_bcd(v));
         expb_q.push_back(ref_blank(ref_bcd(v)));
         load_word(8'(v));
         wait_done(cyc, ok);
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL sweep_timeout din %0d", v); exp_q.delete(); expb_q.delete(); continue; end
         last_bcd = exp_q.pop_front();
         last_blank = expb_q.pop_front();
         n_vec++; if (BCD_OUT !== last_bcd) begin n_err++; $display("FAIL sweep_bcd din %0d got %h want %h", v, BCD_OUT, last_bcd); end
         n_vec++; if (BLANK !== last_blank) begin n_err++; $display("FAIL sweep_blank din %0d got %b want %b", v, BLANK, last_blank); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] e;
      logic [3:0]  eb;
      int c;
      @(negedge CLK);
      for (int t = 0; t <= 21; t++) begin
         if (t > 0) begin
            c = t - 1;
            n_vec++; if (DONE !== ((c == 9) || (c == 18))) begin n_err++; $display("FAIL b2b_done cyc %0d got %b", c, DONE); end
            n_vec++; if (BUSY !== (c <= 17)) begin n_err++; $display("FAIL b2b_busy cyc %0d got %b want %b", c, BUSY, c <= 17); end
            n_vec++; if (BCD_OUT === 16'h0034) begin n_err++; $display("FAIL b2b_dropped cyc %0d got 0034 want not 0034", c); end
            if (DONE === 1'b1) begin
               n_vec++;
               if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra cyc %0d got %h want none", c, BCD_OUT); end
               else begin
                  e = exp_q.pop_front();
                  eb = expb_q.pop_front();
                  if (BCD_OUT !== e || BLANK !== eb) begin
                     n_err++; $display("FAIL b2b_result cyc %0d got %h/%b want %h/%b", c, BCD_OUT, BLANK, e, eb);
                  end
                  last_bcd = e;
                  last_blank = eb;
               end
            end
         end
         LOAD = (t == 0) || (t == 3) || (t == 5);
         if (t == 0) begin DIN = 8'd12; exp_q.push_back(16'h0012); expb_q.push_back(4'b1100); end
         if (t == 3) begin DIN = 8'd34; exp_q.push_back(16'h0034); expb_q.push_back(4'b1100); end
         if (t == 5) begin DIN = 8'd56; exp_q[exp_q.size()-1] = 16'h0056; end
         @(negedge CLK);
      end
      LOAD = 1'b0;
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
      exp_q.delete(); expb_q.delete();
   endtask

   task automatic test_reset_mid;
      int cyc; bit ok;
      exp_q.push_back(16'h0099);
      expb_q.push_back(4'b1100);
      load_word(8'd99);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      #1;
      n_vec++; if (BCD_OUT !== 16'h0000) begin n_err++; $display("FAIL midrst_bcd got %h want 0000", BCD_OUT); end
      n_vec++; if (BLANK !== 4'b1110) begin n_err++; $display("FAIL midrst_blank got %b want 1110", BLANK); end
      n_vec++; if ({BUSY, DONE, VALID} !== 3'b000) begin n_err++; $display("FAIL midrst_flags got %b want 000", {BUSY, DONE, VALID}); end
      @(negedge CLK);
      RESET = 1'b0;
      exp_q.delete(); expb_q.delete();
      for (int i = 0; i < 15; i++) begin
         @(negedge CLK);
         n_vec++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL midrst_quiet cyc %0d got %b%b want 00", i, DONE, BUSY); end
      end
      exp_q.push_back(16'h0042);
      expb_q.push_back(4'b1100);
      load_word(8'd42);
      wait_done(cyc, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL midrst_timeout no DONE for 42"); exp_q.delete(); expb_q.delete(); return; end
      n_vec++; if (cyc != 9) begin n_err++; $display("FAIL midrst_latency got %0d want 9", cyc); end
      last_bcd = exp_q.pop_front();
      last_blank = expb_q.pop_front();
      n_vec++; if (BCD_OUT !== last_bcd || BLANK !== last_blank) begin n_err++; $display("FAIL midrst_result got %h/%b want %h/%b", BCD_OUT, BLANK, last_bcd, last_blank); end
   endtask

   task automatic test_hold;
      bit got;
      got = 1'b0;
      exp_q.push_back(16'h0200);
      expb_q.push_back(4'b1000);
      load_word(8'd200);
      for (int i = 2; i < 20 && !got; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            got = 1'b1;
            n_vec++; if (i != 10) begin n_err++; $display("FAIL hold_latency got %0d want 10", i); end
            last_bcd = exp_q.pop_front();
            last_blank = expb_q.pop_front();
            n_vec++; if (BCD_OUT !== last_bcd || BLANK !== last_blank) begin n_err++; $display("FAIL hold_result got %h/%b want %h/%b", BCD_OUT, BLANK, last_bcd, last_blank); end
            @(negedge CLK);
            n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL hold_done_width got %b want 0", DONE); end
         end else begin
            n_vec++; if (BCD_OUT !== last_bcd || BLANK !== last_blank) begin n_err++; $display("FAIL hold_stable cyc %0d got %h/%b want %h/%b", i, BCD_OUT, BLANK, last_bcd, last_blank); end
         end
      end
      n_vec++; if (!got) begin n_err++; $display("FAIL hold_timeout no DONE for 200"); end
   endtask

   initial begin
      test_reset;
      test_known;
      test_sweep;
      test_back_to_back;
      test_reset_mid;
      test_hold;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
